// File: rtl/simple_pkg.sv
// simple_pkg: definitions shared by the SIMPLE core output-port blocks.
//   DATA_W      default width of an OUT word
//   SEG7_TABLE  hex 0-F to 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}
//   out_state_t handshake FSM states of the output port
package simple_pkg;

   localparam int DATA_W = 16;

   localparam logic [6:0] SEG7_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble  in   4  hex value 0-F
//   seg     out  7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
   import simple_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/out_port_display.sv
// out_port_display: destination of the SIMPLE core's OUT instruction.
// Latches words offered over a valid/ready handshake, mirrors them on LEDs
// and scans them as hex digits on a common-anode 7-segment display.
//
// Handshake: a word transfers on the rising edge where out_valid and
// out_ready are both high. The producer keeps out_valid and out_data stable
// until that edge. out_ready depends only on registered state.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous, active-high
//   out_valid  in   1       word offered this cycle
//   out_data   in   DATA_W  word to display
//   flags_in   in   4       {v,z,c,s} captured with the word (optional)
//   out_ready  out  1       block accepts a word this cycle
//   led        out  DATA_W  latched word
//   flag_led   out  4       latched flags, or 0 when flag capture is off
//   seg_an     out  DIGITS  digit enables, active-low, at most one low
//   seg_cath   out  8       {dp,g,f,e,d,c,b,a}, active-low, dp always off
//
// Build option: define OUT_FLAG_LED_EN to latch flags_in into flag_led on
// each accept; otherwise flag_led is constant zero and flags_in is ignored.
module out_port_display
   import simple_pkg::*;
#(
   parameter int DATA_W      = simple_pkg::DATA_W,
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_CYCLES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                out_valid,
   input  logic [DATA_W-1:0]   out_data,
   input  logic [3:0]          flags_in,
   output logic                out_ready,
   output logic [DATA_W-1:0]   led,
   output logic [3:0]          flag_led,
   output logic [DATA_W/4-1:0] seg_an,
   output logic [7:0]          seg_cath
);

   localparam int DIGITS = DATA_W / 4;
   localparam int SW     = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
   localparam int DW     = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [SW-1:0] PRESC_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

   // ---------------- handshake FSM ----------------
   out_state_t  state, state_next;
   logic [HW-1:0] hold_cnt, hold_cnt_next;
   logic        accept;

   assign accept = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      out_ready     = 1'b0;
      case (state)
         IDLE: begin
            out_ready = 1'b1;
            // hold_cnt counts down from HOLD_CYCLES-1 to 0, giving exactly
            // HOLD_CYCLES cycles of out_ready low after the accept.
            if (out_valid && (HOLD_CYCLES > 0)) begin
               state_next    = HOLD;
               hold_cnt_next = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_next = IDLE;
            end else begin
               hold_cnt_next = hold_cnt - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- latched word and flags ----------------
   logic [DATA_W-1:0] led_q;
   logic              blank;

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= '0;
         blank <= 1'b1;
      end else if (accept) begin
         led_q <= out_data;
         blank <= 1'b0;
      end
   end

   assign led = led_q;

`ifdef OUT_FLAG_LED_EN
   logic [3:0] flag_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q <= '0;
      end else if (accept) begin
         flag_q <= flags_in;
      end
   end

   assign flag_led = flag_q;
`else
   logic unused_flags;

   assign unused_flags = ^flags_in;
   assign flag_led     = 4'b0;
`endif

   // ---------------- scan counters ----------------
   // Free-running; an accept never restarts the scan.
   logic [SW-1:0] presc;
   logic [DW-1:0] dig_idx;
   logic          wrap;

   assign wrap = (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         presc   <= '0;
         dig_idx <= '0;
      end else if (wrap) begin
         presc   <= '0;
         dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
         presc   <= presc + 1'b1;
      end
   end

   // ---------------- display outputs ----------------
   // Registered from led_q/dig_idx/blank, so the display lags the latched
   // word by one edge; an accept coinciding with a digit wrap therefore
   // shows the new digit of the new word.
   logic [3:0]        nibble;
   logic [6:0]        seg_pat;
   logic [DIGITS-1:0] an_next;

   assign nibble = led_q[{dig_idx, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (seg_pat)
   );

   always_comb begin
      an_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         an_next[i] = (dig_idx != DW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset || blank) begin
         seg_an   <= '1;
         seg_cath <= 8'hFF;
      end else begin
         seg_an   <= an_next;
         seg_cath <= {1'b1, seg_pat};
      end
   end

endmodule
